// File: rtl/tunnel_pkg.sv
// tunnel_pkg: shared definitions for the tunnel game controller and the
// icon/wall video controller that consumes game_info_reg.
//   - game_state_t     : state encoding seen on the game_state output
//   - GI_*             : game_info_reg bit positions
//   - DRIFT_*          : wall drift codes carried in game_info_reg[2:1]
//   - DEF_*            : default parameter values
//   - lfsr8_next       : one step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR
//   - drift_code       : maps raw LFSR bits to a legal drift code
package tunnel_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_PAUSE     = 3'd3,
      ST_HIT       = 3'd4,
      ST_GAME_OVER = 3'd5
   } game_state_t;

   localparam int GI_MOVE_LEFT = 0;
   localparam int GI_DRIFT_LO  = 1;
   localparam int GI_DRIFT_HI  = 2;
   localparam int GI_RUNNING   = 3;
   localparam int GI_HIT       = 4;
   localparam int GI_LIVES_LO  = 5;
   localparam int GI_LIVES_HI  = 7;

   localparam logic [1:0] DRIFT_HOLD = 2'b00;
   localparam logic [1:0] DRIFT_DOWN = 2'b01;
   localparam logic [1:0] DRIFT_UP   = 2'b10;

   localparam int         DEF_COUNTDOWN_FRAMES = 60;
   localparam int         DEF_HIT_FRAMES       = 30;
   localparam int         DEF_WALL_PERIOD      = 8;
   localparam int         DEF_LIVES            = 3;
   localparam logic [7:0] DEF_LFSR_SEED        = 8'hA5;

   // Taps 8,6,5,4 -> bits 7,5,4,3; maximal length, so a nonzero seed never reaches 0.
   function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

   // 2'b11 is not a drift direction; treat it as hold.
   function automatic logic [1:0] drift_code(input logic [1:0] raw);
      return (raw == 2'b11) ? DRIFT_HOLD : raw;
   endfunction

endpackage

// File: rtl/tunnel_game_sequencer_if.sv
// tunnel_game_sequencer_if: buttons and video datapath inputs plus the game
// outputs of the tunnel game sequencer.
//   master : board/video side, drives buttons and pixel stream, reads results
//   slave  : the sequencer
// There is no valid/ready handshake on this bus: buttons are debounced levels,
// the pixel inputs are qualified by the (0,0) start-of-frame position, and
// every output is a register that changes only on a clock edge.
interface tunnel_game_sequencer_if;
   import tunnel_pkg::*;

   logic        btn_start;
   logic        btn_left;
   logic        btn_right;
   logic [9:0]  Pixel_row;
   logic [9:0]  Pixel_column;
   logic [1:0]  icon;
   logic [1:0]  wall;
   logic [7:0]  game_info_reg;
   logic [15:0] score;
   game_state_t game_state;
   logic        frame_tick;

   modport master (
      output btn_start, btn_left, btn_right, Pixel_row, Pixel_column, icon, wall,
      input  game_info_reg, score, game_state, frame_tick
   );

   modport slave (
      input  btn_start, btn_left, btn_right, Pixel_row, Pixel_column, icon, wall,
      output game_info_reg, score, game_state, frame_tick
   );

endinterface

// File: rtl/tunnel_lfsr8.sv
// tunnel_lfsr8: 8-bit Fibonacci LFSR used for wall drift.
//   clock, rst : clock and synchronous active-high reset (loads seed)
//   load       : load seed (game start)
//   seed       : value loaded on reset and load
//   advance    : step once
//   q          : current LFSR value
module tunnel_lfsr8
   import tunnel_pkg::*;
(
   input  logic       clock,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       advance,
   output logic [7:0] q
);

   always_ff @(posedge clock) begin
      if (rst || load) begin
         q <= seed;
      end else if (advance) begin
         q <= lfsr8_next(q);
      end
   end

endmodule

// File: rtl/tunnel_game_sequencer.sv
// tunnel_game_sequencer: frame-level controller for the tunnel game.
// Sequences IDLE/COUNTDOWN/PLAY/PAUSE/HIT/GAME_OVER, detects icon/wall
// coincidence, keeps lives and a saturating score and drives game_info_reg.
//   clock : 25 MHz pixel clock
//   rst   : synchronous active-high reset
//   bus   : tunnel_game_sequencer_if.slave (buttons, pixel stream, outputs)
// All outputs are registered and update on the edge closing the sof cycle.
module tunnel_game_sequencer
   import tunnel_pkg::*;
#(
   parameter int         COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
   parameter int         HIT_FRAMES       = DEF_HIT_FRAMES,
   parameter int         WALL_PERIOD      = DEF_WALL_PERIOD,
   parameter int         LIVES            = DEF_LIVES,
   parameter logic [7:0] LFSR_SEED        = DEF_LFSR_SEED
) (
   input logic                    clock,
   input logic                    rst,
   tunnel_game_sequencer_if.slave bus
);

   localparam int CNT_MAX = (COUNTDOWN_FRAMES > HIT_FRAMES) ? COUNTDOWN_FRAMES : HIT_FRAMES;
   localparam int CW      = $clog2(CNT_MAX + 1) + 1;
   localparam int WW      = $clog2(WALL_PERIOD + 1) + 1;
   localparam logic [2:0] LIVES_INIT = 3'(LIVES);

   game_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WW-1:0] wall_cnt_q, wall_cnt_d;
   logic [2:0]    lives_q, lives_d;
   logic [15:0]   score_q, score_d;
   logic          hit_pending_q, hit_pending_d;
   logic          move_q, move_d;
   logic [1:0]    drift_q, drift_d;
   logic [7:0]    info_q;
   logic          tick_q;
   logic          at0_q, btn_start_q;
   logic          lfsr_load, lfsr_adv;
   logic [7:0]    lfsr_q;

   logic at0, sof, start_edge, coincide, hit;

   assign at0        = (bus.Pixel_row == 10'd0) && (bus.Pixel_column == 10'd0);
   assign sof        = at0 && !at0_q;
   assign start_edge = bus.btn_start && !btn_start_q;
   assign coincide   = (bus.icon != 2'b00) && (bus.wall != 2'b00);

   tunnel_lfsr8 u_lfsr (
      .clock   (clock),
      .rst     (rst),
      .load    (lfsr_load),
      .seed    (LFSR_SEED),
      .advance (lfsr_adv),
      .q       (lfsr_q)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         wall_cnt_q    <= '0;
         lives_q       <= 3'd0;
         score_q       <= 16'd0;
         hit_pending_q <= 1'b0;
         move_q        <= 1'b0;
         drift_q       <= DRIFT_HOLD;
         info_q        <= 8'h00;
         tick_q        <= 1'b0;
         at0_q         <= 1'b0;
         btn_start_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wall_cnt_q    <= wall_cnt_d;
         lives_q       <= lives_d;
         score_q       <= score_d;
         hit_pending_q <= hit_pending_d;
         move_q        <= move_d;
         drift_q       <= drift_d;
         info_q        <= {lives_d, state_d == ST_HIT, state_d == ST_PLAY, drift_d, move_d};
         tick_q        <= sof;
         at0_q         <= at0;
         btn_start_q   <= bus.btn_start;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wall_cnt_d    = wall_cnt_q;
      lives_d       = lives_q;
      score_d       = score_q;
      hit_pending_d = hit_pending_q;
      move_d        = move_q;
      drift_d       = drift_q;
      lfsr_load     = 1'b0;
      lfsr_adv      = 1'b0;
      hit           = hit_pending_q | coincide;

      if (sof) begin
         move_d = bus.btn_left && !bus.btn_right;
      end

      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            drift_d       = DRIFT_HOLD;
            cnt_d         = '0;
            hit_pending_d = 1'b0;
            if (start_edge) begin
               state_d    = ST_COUNTDOWN;
               lives_d    = LIVES_INIT;
               score_d    = 16'd0;
               cnt_d      = CW'(COUNTDOWN_FRAMES);
               wall_cnt_d = '0;
               lfsr_load  = 1'b1;
            end
         end
         ST_COUNTDOWN: begin
            drift_d       = DRIFT_HOLD;
            hit_pending_d = 1'b0;
            if (sof) begin
               if (cnt_q <= CW'(1)) begin
                  state_d = ST_PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         ST_PLAY: begin
            // A pause press wins over a coincident sof and drops any pending hit.
            if (start_edge) begin
               state_d       = ST_PAUSE;
               hit_pending_d = 1'b0;
            end else if (sof) begin
               hit_pending_d = 1'b0;
               if (hit && lives_q <= 3'd1) begin
                  lives_d = 3'd0;
                  drift_d = DRIFT_HOLD;
                  state_d = ST_GAME_OVER;
               end else if (hit) begin
                  lives_d = lives_q - 3'd1;
                  cnt_d   = CW'(HIT_FRAMES);
                  state_d = ST_HIT;
               end else begin
                  if (score_q != 16'hFFFF) begin
                     score_d = score_q + 16'd1;
                  end
                  if (wall_cnt_q >= WW'(WALL_PERIOD - 1)) begin
                     wall_cnt_d = '0;
                     lfsr_adv   = 1'b1;
                     drift_d    = drift_code(lfsr8_next(lfsr_q)[1:0]);
                  end else begin
                     wall_cnt_d = wall_cnt_q + WW'(1);
                  end
               end
            end else if (coincide) begin
               hit_pending_d = 1'b1;
            end
         end
         ST_PAUSE: begin
            hit_pending_d = 1'b0;
            if (start_edge) begin
               state_d = ST_PLAY;
            end
         end
         ST_HIT: begin
            hit_pending_d = 1'b0;
            if (sof) begin
               if (cnt_q <= CW'(1)) begin
                  state_d = ST_PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            drift_d = DRIFT_HOLD;
         end
      endcase
   end

   assign bus.game_info_reg = info_q;
   assign bus.score         = score_q;
   assign bus.game_state    = state_q;
   assign bus.frame_tick    = tick_q;

endmodule

// File: tb/tb_tunnel_game_sequencer.sv
// Directed bench for tunnel_game_sequencer with an expected-value queue:
// every frame pushes the expected {state, game_info_reg, score} and the
// checker pops it on the matching frame_tick.
module tb_tunnel_game_sequencer;
   import tunnel_pkg::*;

   localparam int         P_COUNTDOWN = 3;
   localparam int         P_HIT       = 2;
   localparam int         P_WALL      = 2;
   localparam int         P_LIVES     = 3;
   localparam logic [7:0] P_SEED      = 8'hA5;

   logic clock;
   logic rst;

   tunnel_game_sequencer_if bus ();

   tunnel_game_sequencer #(
      .COUNTDOWN_FRAMES (P_COUNTDOWN),
      .HIT_FRAMES       (P_HIT),
      .WALL_PERIOD      (P_WALL),
      .LIVES            (P_LIVES),
      .LFSR_SEED        (P_SEED)
   ) dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus.slave)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   logic [26:0] exp_q[$];

   // reference state of the game as the bench expects it
   logic [2:0]  m_state;
   logic [2:0]  m_lives;
   logic [15:0] m_score;
   logic [1:0]  m_drift;
   logic        m_move;
   logic [7:0]  m_lfsr;
   int          m_wall;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] q);
      logic fb;
      fb = q[7] ^ q[5] ^ q[4] ^ q[3];
      return {q[6:0], fb};
   endfunction

   function automatic logic [7:0] exp_info(input logic [2:0] st, input logic [2:0] lv,
                                           input logic [1:0] dr, input logic mv);
      return {lv, st == 3'd4, st == 3'd2, dr, mv};
   endfunction

   // scoreboard: one expected entry per frame_tick
   always @(negedge clock) begin
      logic [26:0] e;
      if (!rst && bus.frame_tick) begin
         if (exp_q.size() == 0) begin
            check("unexpected_frame_tick", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("frame_state", 32'(bus.game_state), 32'(e[26:24]));
            check("frame_info", 32'(bus.game_info_reg), 32'(e[23:16]));
            check("frame_score", 32'(bus.score), 32'(e[15:0]));
         end
      end
   end

   // drivers
   task automatic frame(input logic [2:0] nxt, input bit tick, input bit coll,
                        input bit left, input bit right);
      @(negedge clock);
      m_move = left && !right;
      if (tick) begin
         if (m_score != 16'hFFFF) m_score = m_score + 16'd1;
         m_wall++;
         if (m_wall == P_WALL) begin
            m_wall  = 0;
            m_lfsr  = lfsr_step(m_lfsr);
            m_drift = (m_lfsr[1:0] == 2'b11) ? 2'b00 : m_lfsr[1:0];
         end
      end
      m_state = nxt;
      if (nxt == 3'd0 || nxt == 3'd1 || nxt == 3'd5) m_drift = 2'b00;
      exp_q.push_back({m_state, exp_info(m_state, m_lives, m_drift, m_move), m_score});
      bus.Pixel_row    = 10'd0;
      bus.Pixel_column = 10'd0;
      bus.btn_left     = left;
      bus.btn_right    = right;
      @(negedge clock);
      bus.Pixel_row    = 10'd12;
      bus.Pixel_column = 10'd34;
      if (coll) begin
         bus.icon = 2'd1;
         bus.wall = 2'd2;
      end
      @(negedge clock);
      bus.icon = 2'd0;
      bus.wall = 2'd0;
      @(negedge clock);
   endtask

   task automatic press_start(input logic [2:0] nxt, input string tag);
      @(negedge clock);
      bus.btn_start = 1'b1;
      @(negedge clock);
      bus.btn_start = 1'b0;
      m_state = nxt;
      check({tag, "_state"}, 32'(bus.game_state), 32'(m_state));
      check({tag, "_info"}, 32'(bus.game_info_reg), 32'(exp_info(m_state, m_lives, m_drift, m_move)));
      check({tag, "_score"}, 32'(bus.score), 32'(m_score));
   endtask

   task automatic new_game();
      m_lives = 3'(P_LIVES);
      m_score = 16'd0;
      m_lfsr  = P_SEED;
      m_wall  = 0;
      m_drift = 2'b00;
   endtask

   initial begin
      rst              = 1'b1;
      bus.btn_start    = 1'b0;
      bus.btn_left     = 1'b0;
      bus.btn_right    = 1'b0;
      bus.Pixel_row    = 10'd5;
      bus.Pixel_column = 10'd5;
      bus.icon         = 2'd0;
      bus.wall         = 2'd0;
      m_state = 3'd0; m_lives = 3'd0; m_score = 16'd0; m_drift = 2'b00;
      m_move = 1'b0; m_lfsr = P_SEED; m_wall = 0;

      // reset state
      repeat (3) @(negedge clock);
      check("reset_state", 32'(bus.game_state), 32'd0);
      check("reset_info", 32'(bus.game_info_reg), 32'h00);
      check("reset_score", 32'(bus.score), 32'd0);
      check("reset_tick", 32'(bus.frame_tick), 32'd0);
      rst = 1'b0;

      // move bit only changes at sof
      @(negedge clock);
      bus.btn_left = 1'b1;
      @(negedge clock);
      check("move_before_sof", 32'(bus.game_info_reg[0]), 32'd0);
      frame(3'd0, 0, 0, 1, 0);

      // start, countdown of 3 frames, then play
      new_game();
      press_start(3'd1, "start1");
      frame(3'd1, 0, 0, 1, 0);
      frame(3'd1, 0, 0, 1, 0);
      frame(3'd2, 0, 0, 0, 0);

      // play ticks with button mixes; drift moves every 2nd tick
      frame(3'd2, 1, 0, 1, 0);
      frame(3'd2, 1, 0, 1, 1);
      frame(3'd2, 1, 0, 0, 1);
      frame(3'd2, 1, 0, 0, 0);

      // mid-frame collision -> HIT at next sof; collisions ignored in HIT
      frame(3'd2, 1, 1, 0, 0);
      m_lives = 3'd2;
      frame(3'd4, 0, 0, 0, 0);
      frame(3'd4, 0, 1, 0, 0);
      frame(3'd2, 0, 0, 0, 0);
      frame(3'd2, 1, 0, 0, 0);

      // pending hit dropped by pause; score and drift held while paused
      frame(3'd2, 1, 1, 0, 0);
      press_start(3'd3, "pause");
      repeat (5) frame(3'd3, 0, 0, 0, 0);
      press_start(3'd2, "resume");
      frame(3'd2, 1, 0, 1, 0);

      // score saturation from a preloaded value
      @(negedge clock);
      force dut.score_q = 16'hFFFE;
      @(negedge clock);
      release dut.score_q;
      m_score = 16'hFFFE;
      frame(3'd2, 1, 0, 0, 0);
      frame(3'd2, 1, 0, 0, 0);
      frame(3'd2, 1, 0, 0, 0);

      // second and third hits -> game over, score frozen
      frame(3'd2, 1, 1, 0, 0);
      m_lives = 3'd1;
      frame(3'd4, 0, 0, 0, 0);
      frame(3'd4, 0, 0, 0, 0);
      frame(3'd2, 0, 0, 0, 0);
      frame(3'd2, 1, 1, 0, 0);
      m_lives = 3'd0;
      frame(3'd5, 0, 0, 0, 0);
      frame(3'd5, 0, 0, 1, 0);

      // restart from game over
      new_game();
      press_start(3'd1, "restart");
      frame(3'd1, 0, 0, 0, 0);
      frame(3'd1, 0, 0, 0, 0);
      frame(3'd2, 0, 0, 0, 0);
      frame(3'd2, 1, 1, 0, 0);
      m_lives = 3'd2;
      frame(3'd4, 0, 0, 0, 0);

      // reset in the middle of HIT
      @(negedge clock);
      rst = 1'b1;
      @(negedge clock);
      check("midhit_rst_state", 32'(bus.game_state), 32'd0);
      check("midhit_rst_info", 32'(bus.game_info_reg), 32'h00);
      check("midhit_rst_score", 32'(bus.score), 32'd0);
      check("midhit_rst_tick", 32'(bus.frame_tick), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clock);

      check("frames_left_unseen", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
